prra_arbiter: RTL and testbench

Registered, packet-locking round-robin arbiter for router output ports. Grants one of WIDTH requesters using a rotating priority pointer. The grant stays locked until the current owner signals end of packet. It generalises the combinational PRRA lookup with several additions:
- a stateful pointer
- per-input masking
- optional zero-bubble handover
- support for non-power-of-two WIDTH

---
 rtl/prra_arbiter.sv | 138 +++++++++++++
 tb/tb_prra_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prra_arbiter.sv
// prra_arbiter: registered, packet-locking round-robin arbiter.
//
// Grants one of WIDTH requesters. Priority rotates from the last winner
// (pointer). A grant stays locked until the owner signals end of packet.
// WIDTH does not have to be a power of two.
//
// Parameters
//   WIDTH        number of requesters (1..16)
//   LOG2_WIDTH   width of grant_id / pointer (2**LOG2_WIDTH >= WIDTH, >= 1)
//   STATE_OFFSET reset value of the priority pointer (< WIDTH)
//   HANDOVER     1 = re-arbitrate on the release edge, 0 = idle cycle after release
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   request      per-requester request level
//   enable       per-requester mask (0 = request ignored)
//   release_pkt  end of packet from the current owner, ignored while idle
//                (named release_pkt because "release" is a reserved word)
//   grant        one-hot registered grant, zero when idle
//   grant_id     index of the granted requester, holds last owner when idle
//   grant_valid  a grant is active
//   pointer      current priority pointer (last winner)
module prra_arbiter #(
  parameter int WIDTH        = 4,
  parameter int LOG2_WIDTH   = 2,
  parameter int STATE_OFFSET = 0,
  parameter int HANDOVER     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      request,
  input  logic [WIDTH-1:0]      enable,
  input  logic                  release_pkt,
  output logic [WIDTH-1:0]      grant,
  output logic [LOG2_WIDTH-1:0] grant_id,
  output logic                  grant_valid,
  output logic [LOG2_WIDTH-1:0] pointer
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [LOG2_WIDTH-1:0] PTR_RST = LOG2_WIDTH'(STATE_OFFSET);

  logic [0:0]            state;
  logic [WIDTH-1:0]      grant_q;
  logic [LOG2_WIDTH-1:0] ptr_q;

  logic [WIDTH-1:0]      eff;
  logic [WIDTH-1:0]      cand;
  logic                  win_found;
  logic [LOG2_WIDTH-1:0] win_idx;
  logic                  owner_req;

  // First set bit of vec starting just after ptr, wrapping modulo WIDTH
  // (never 2**LOG2_WIDTH, so out-of-range indices cannot appear).
  // Returns {found, index}.
  function automatic logic [LOG2_WIDTH:0] find_winner(
    input logic [WIDTH-1:0]      vec,
    input logic [LOG2_WIDTH-1:0] ptr
  );
    logic                  found;
    logic [LOG2_WIDTH-1:0] idx;
    logic [WIDTH-1:0]      sh;
    int                    l;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < WIDTH; k++) begin
      l  = (int'(ptr) + 1 + k) % WIDTH;
      sh = vec >> l;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = LOG2_WIDTH'(l);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [WIDTH-1:0] one_hot(input logic [LOG2_WIDTH-1:0] idx);
    return WIDTH'(1) << idx;
  endfunction

  // While busy the owner is removed from the search so that, on release,
  // any other requester wins first; the owner only keeps the grant when
  // nobody else is asking.
  always_comb begin
    eff                  = request & enable;
    cand                 = (state == ST_BUSY) ? (eff & ~grant_q) : eff;
    {win_found, win_idx} = find_winner(cand, ptr_q);
    owner_req            = |(eff & grant_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state   <= ST_BUSY;
            grant_q <= one_hot(win_idx);
            ptr_q   <= win_idx;
          end
        end
        ST_BUSY: begin
          if (release_pkt) begin
            if (HANDOVER != 0) begin
              if (win_found) begin
                grant_q <= one_hot(win_idx);
                ptr_q   <= win_idx;
              end else if (!owner_req) begin
                state   <= ST_IDLE;
                grant_q <= '0;
              end
            end else begin
              state   <= ST_IDLE;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // The owner index and the priority pointer are the same quantity: the
  // last winner. Both outputs come straight from registers.
  assign grant       = grant_q;
  assign grant_id    = ptr_q;
  assign pointer     = ptr_q;
  assign grant_valid = (state == ST_BUSY);

endmodule

// File: tb/tb_prra_arbiter.sv
// tb_prra_arbiter: bench for prra_arbiter.
// Three instances share one stimulus stream:
//   a: WIDTH=4, STATE_OFFSET=0, HANDOVER=1
//   b: WIDTH=4, STATE_OFFSET=0, HANDOVER=0
//   c: WIDTH=3, STATE_OFFSET=2, HANDOVER=1
// A behavioural model (owner/pointer/valid per instance) predicts every
// output at each falling edge; directed literals pin key scenarios.
module tb_prra_arbiter;

  typedef struct {
    int valid;
    int owner;
    int ptr;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] en;
  logic       rel;

  logic [3:0] ga, gb;
  logic [2:0] gc;
  logic [1:0] ida, idb, idc;
  logic [1:0] pa, pb, pc;
  logic       va, vb, vc;

  mstate_t ma, mb, mc;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prra_arbiter #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(0), .HANDOVER(1)) dut_a (
    .clk(clk), .rst(rst), .request(req), .enable(en), .release_pkt(rel),
    .grant(ga), .grant_id(ida), .grant_valid(va), .pointer(pa));

  prra_arbiter #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(0), .HANDOVER(0)) dut_b (
    .clk(clk), .rst(rst), .request(req), .enable(en), .release_pkt(rel),
    .grant(gb), .grant_id(idb), .grant_valid(vb), .pointer(pb));

  prra_arbiter #(.WIDTH(3), .LOG2_WIDTH(2), .STATE_OFFSET(2), .HANDOVER(1)) dut_c (
    .clk(clk), .rst(rst), .request(req[2:0]), .enable(en[2:0]), .release_pkt(rel),
    .grant(gc), .grant_id(idc), .grant_valid(vc), .pointer(pc));

  function automatic mstate_t mreset(input int off);
    mstate_t s;
    s.valid = 0;
    s.owner = off;
    s.ptr   = off;
    return s;
  endfunction

  // Next state from the arbitration rules: search from last winner + 1,
  // modulo w; on handover the owner is skipped and only kept as fallback.
  function automatic mstate_t mnext(input mstate_t s, input int w, input int ho,
                                    input logic [3:0] r, input logic [3:0] e,
                                    input logic rl);
    mstate_t    n;
    int         win;
    int         l;
    logic [3:0] effv;
    n    = s;
    win  = -1;
    effv = r & e;
    if (s.valid == 0) begin
      for (int k = 1; k <= w; k++) begin
        l = (s.ptr + k) % w;
        if (win < 0 && effv[l]) win = l;
      end
      if (win >= 0) begin
        n.valid = 1;
        n.owner = win;
        n.ptr   = win;
      end
    end else if (rl) begin
      if (ho == 0) begin
        n.valid = 0;
      end else begin
        for (int k = 1; k <= w; k++) begin
          l = (s.ptr + k) % w;
          if (win < 0 && l != s.owner && effv[l]) win = l;
        end
        if (win >= 0) begin
          n.owner = win;
          n.ptr   = win;
        end else if (!effv[s.owner]) begin
          n.valid = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_dut(input string nm, input mstate_t m, input int g,
                           input int id, input int v, input int p);
    chk({nm, ".grant"},       g,  (m.valid != 0) ? (1 << m.owner) : 0);
    chk({nm, ".grant_id"},    id, m.owner);
    chk({nm, ".grant_valid"}, v,  m.valid);
    chk({nm, ".pointer"},     p,  m.ptr);
    chk({nm, ".onehot"},      int'($countones(g) <= 1), 1);
    chk({nm, ".valid_or"},    v,  int'(g != 0));
    if (v != 0) chk({nm, ".grant_at_id"}, (g >> id) & 1, 1);
  endtask

  task automatic compare_all();
    check_dut("a", ma, int'(ga), int'(ida), int'(va), int'(pa));
    check_dut("b", mb, int'(gb), int'(idb), int'(vb), int'(pb));
    check_dut("c", mc, int'(gc), int'(idc), int'(vc), int'(pc));
  endtask

  task automatic models_reset();
    ma = mreset(0);
    mb = mreset(0);
    mc = mreset(2);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      models_reset();
    end else begin
      ma = mnext(ma, 4, 1, req, en, rel);
      mb = mnext(mb, 4, 0, req, en, rel);
      mc = mnext(mc, 3, 1, req, en, rel);
    end
    @(negedge clk);
    compare_all();
  endtask

  int exp_seq[4] = '{4, 8, 1, 2};

  initial begin
    rst = 1'b1;
    req = '0;
    en  = '0;
    rel = 1'b0;
    models_reset();

    // reset state
    @(negedge clk);
    compare_all();
    chk("lit_rst_grant_a", int'(ga), 0);
    chk("lit_rst_valid_a", int'(va), 0);
    chk("lit_rst_ptr_a",   int'(pa), 0);
    chk("lit_rst_ptr_c",   int'(pc), 2);

    // first grant: one cycle after requests appear
    rst = 1'b0;
    req = 4'hF;
    en  = 4'hF;
    step();
    chk("lit_first_grant_a", int'(ga), 2);
    chk("lit_first_id_a",    int'(ida), 1);
    chk("lit_wrap_id_c",     int'(idc), 0);
    chk("lit_wrap_grant_c",  int'(gc), 1);

    // rotating handover: release every third cycle
    for (int i = 0; i < 4; i++) begin
      rel = 1'b0;
      step();
      if (i > 0) chk("lit_b_regrant", int'(gb), exp_seq[i-1]);
      step();
      rel = 1'b1;
      step();
      rel = 1'b0;
      chk("lit_a_handover", int'(ga), exp_seq[i]);
      chk("lit_b_idle",     int'(vb), 0);
    end
    step();
    chk("lit_b_regrant", int'(gb), exp_seq[3]);

    // lock holds while owner drops request
    rel = 1'b1;
    step();
    chk("lit_lock_start", int'(ga), 4);
    rel = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lit_lock_hold", int'(ga), 4);
    end
    rel = 1'b1;
    step();
    chk("lit_lock_after", int'(ga), 1);

    // masked input skipped
    req = 4'b0010;
    step();
    chk("lit_ptr1", int'(pa), 1);
    req = 4'hF;
    en  = 4'b1011;
    step();
    chk("lit_mask_skip", int'(ga), 8);
    en  = 4'hF;

    // asynchronous reset mid-packet
    req = 4'b0100;
    step();
    chk("lit_pre_rst", int'(ga), 4);
    rel = 1'b0;
    rst = 1'b1;
    #1;
    models_reset();
    compare_all();
    chk("lit_async_grant", int'(ga), 0);
    chk("lit_async_valid", int'(va), 0);
    chk("lit_async_ptr",   int'(pa), 0);
    #1;
    rst = 1'b0;
    step();
    chk("lit_post_rst", int'(ga), 4);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      req = 4'($urandom);
      en  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      rel = ($urandom_range(2) == 0);
      rst = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0;
    rel = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
